// File: rtl/test_sequencer.sv
// Runs enabled test channels in index order with a start/done/pass handshake,
// a per-test watchdog, and pass/fail/timeout tallies for the run.
module test_sequencer #(
    parameter int NUM_TESTS      = 8,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16,
    parameter int IDX_W          = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_TESTS-1:0] enable_mask,
    input  logic [NUM_TESTS-1:0] test_done,
    input  logic [NUM_TESTS-1:0] test_pass,
    output logic [NUM_TESTS-1:0] test_start,
    output logic                 busy,
    output logic                 finished,
    output logic                 all_passed,
    output logic [IDX_W-1:0]     current_test,
    output logic [IDX_W:0]       pass_count,
    output logic [IDX_W:0]       fail_count,
    output logic [IDX_W:0]       timeout_count,
    output logic [NUM_TESTS-1:0] fail_vector
);

    typedef enum logic [2:0] {IDLE, SELECT, LAUNCH, WAIT, RECORD, DONE} state_t;

    state_t               state, state_nxt;
    logic [NUM_TESTS-1:0] mask;
    logic [IDX_W:0]       search_idx;
    logic [CNT_W-1:0]     watchdog;
    logic                 res_pass, res_timeout;
    logic                 found;
    logic [IDX_W-1:0]     found_idx;
    logic [NUM_TESTS-1:0] done_sh, pass_sh;
    logic                 cur_done, timeout_hit, last_test;

    assign done_sh     = test_done >> current_test;
    assign pass_sh     = test_pass >> current_test;
    assign cur_done    = done_sh[0];
    assign timeout_hit = (watchdog == CNT_W'(TIMEOUT_CYCLES - 1));
    assign last_test   = (({1'b0, current_test} + 1'b1) == (IDX_W+1)'(NUM_TESTS));

    // Lowest enabled channel at or above the search index.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int unsigned i = 0; i < NUM_TESTS; i++) begin
            if (!found && i >= 32'(search_idx) && mask[i]) begin
                found     = 1'b1;
                found_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (state != IDLE && abort) begin
            state_nxt = DONE;
        end else begin
            case (state)
                IDLE, DONE: if (start) state_nxt = SELECT;
                SELECT:     state_nxt = found ? LAUNCH : DONE;
                LAUNCH:     state_nxt = WAIT;
                WAIT:       if (cur_done || timeout_hit) state_nxt = RECORD;
                RECORD:     state_nxt = last_test ? DONE : SELECT;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mask          <= '0;
            search_idx    <= '0;
            watchdog      <= '0;
            res_pass      <= 1'b0;
            res_timeout   <= 1'b0;
            test_start    <= '0;
            busy          <= 1'b0;
            finished      <= 1'b0;
            all_passed    <= 1'b0;
            current_test  <= '0;
            pass_count    <= '0;
            fail_count    <= '0;
            timeout_count <= '0;
            fail_vector   <= '0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt == LAUNCH) || (state_nxt == WAIT) || (state_nxt == RECORD);
            finished   <= (state_nxt == DONE);
            test_start <= '0;
            if (state != IDLE && abort) begin
                // In-flight result is dropped and the pending launch never issues.
                all_passed <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            mask          <= enable_mask;
                            search_idx    <= '0;
                            watchdog      <= '0;
                            current_test  <= '0;
                            all_passed    <= 1'b0;
                            pass_count    <= '0;
                            fail_count    <= '0;
                            timeout_count <= '0;
                            fail_vector   <= '0;
                        end
                    end
                    SELECT: begin
                        if (found) begin
                            current_test <= found_idx;
                            test_start   <= NUM_TESTS'(1) << found_idx;
                        end else begin
                            all_passed <= (fail_count == '0) && (pass_count != '0);
                        end
                    end
                    LAUNCH: watchdog <= '0;
                    WAIT: begin
                        if (cur_done) begin
                            res_pass    <= pass_sh[0];
                            res_timeout <= 1'b0;
                        end else if (timeout_hit) begin
                            res_pass    <= 1'b0;
                            res_timeout <= 1'b1;
                        end else begin
                            watchdog <= watchdog + 1'b1;
                        end
                    end
                    RECORD: begin
                        if (res_pass) begin
                            pass_count <= pass_count + 1'b1;
                        end else begin
                            fail_count  <= fail_count + 1'b1;
                            fail_vector <= fail_vector | (NUM_TESTS'(1) << current_test);
                        end
                        if (res_timeout) timeout_count <= timeout_count + 1'b1;
                        search_idx <= {1'b0, current_test} + 1'b1;
                        // Going straight to DONE: the count update lands on the same edge.
                        if (last_test) all_passed <= res_pass && (fail_count == '0);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Randomised bench for test_sequencer: a per-channel device model plus a
// schedule-level reference of launches, tallies and finish time.
module tb_test_sequencer;

    localparam int N  = 4;
    localparam int TO = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] enable_mask = '0;
    logic [N-1:0] test_done = '0;
    logic [N-1:0] test_pass = '0;
    logic [N-1:0] test_start;
    logic         busy, finished, all_passed;
    logic [1:0]   current_test;
    logic [2:0]   pass_count, fail_count, timeout_count;
    logic [N-1:0] fail_vector;

    int checks = 0;
    int errors = 0;
    int cfg_lat [N];   // WAIT cycle on which the device signals done; 0 = hangs
    bit cfg_pass [N];

    test_sequencer #(.NUM_TESTS(N), .TIMEOUT_CYCLES(TO), .CNT_W(8), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .enable_mask(enable_mask), .test_done(test_done), .test_pass(test_pass),
        .test_start(test_start), .busy(busy), .finished(finished),
        .all_passed(all_passed), .current_test(current_test),
        .pass_count(pass_count), .fail_count(fail_count),
        .timeout_count(timeout_count), .fail_vector(fail_vector)
    );

    always #5 clk = ~clk;

    // Launches a run from a sample point and checks it cycle by cycle until it settles.
    task automatic run_and_check(input string name, input logic [N-1:0] m,
                                 input int abort_at, input bit noise);
        int lcyc [N];
        bit launched [N];
        int t, fin, ep, ef, et, act, ab;
        logic [N-1:0] efv, exp_ts, td, tp;
        bit eap;
        t = 2; fin = 2; ep = 0; ef = 0; et = 0; efv = '0; act = -1;
        ab = (abort_at >= 1) ? abort_at : 1 << 30;
        for (int ch = 0; ch < N; ch++) begin
            launched[ch] = 1'b0;
            lcyc[ch] = 0;
            if (m[ch] && t <= ab) begin
                int j, rec;
                j = (cfg_lat[ch] != 0 && cfg_lat[ch] <= TO) ? cfg_lat[ch] : TO;
                launched[ch] = 1'b1;
                lcyc[ch] = t;
                rec = t + j + 1;
                fin = (ch == N - 1) ? t + j + 2 : t + j + 3;
                if (rec < ab) begin
                    if (cfg_lat[ch] != 0 && cfg_lat[ch] <= TO && cfg_pass[ch]) ep++;
                    else begin
                        ef++;
                        efv[ch] = 1'b1;
                        if (cfg_lat[ch] == 0 || cfg_lat[ch] > TO) et++;
                    end
                end
                t = t + j + 3;
            end
        end
        eap = (ef == 0) && (ep != 0);
        if (abort_at >= 1 && abort_at <= fin + 1) begin
            eap = 1'b0;
            if (abort_at + 1 < fin) fin = abort_at + 1;
        end

        start = 1'b1; enable_mask = m; abort = 1'b0; test_done = '0;
        for (int c = 1; c <= fin + 2; c++) begin
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0;
            exp_ts = '0;
            for (int ch = 0; ch < N; ch++)
                if (launched[ch] && lcyc[ch] == c) begin exp_ts[ch] = 1'b1; act = ch; end
            checks++;
            if (test_start !== exp_ts) begin
                errors++;
                $display("FAIL %s test_start c=%0d got %b want %b", name, c, test_start, exp_ts);
            end
            checks++;
            if (finished !== (c >= fin)) begin
                errors++;
                $display("FAIL %s finished c=%0d got %b want %b", name, c, finished, c >= fin);
            end
            if (exp_ts != '0) begin
                checks++;
                if (busy !== 1'b1 || current_test !== 2'(act)) begin
                    errors++;
                    $display("FAIL %s launch c=%0d busy %b cur %0d want 1 %0d", name, c, busy, current_test, act);
                end
            end
            td = '0;
            tp = N'($urandom);
            if (noise) begin
                td = N'($urandom & $urandom);
                if (act >= 0) td[act] = 1'b0;
            end
            for (int ch = 0; ch < N; ch++)
                if (launched[ch] && cfg_lat[ch] != 0 && c == lcyc[ch] + cfg_lat[ch]) begin
                    td[ch] = 1'b1;
                    tp[ch] = cfg_pass[ch];
                end
            test_done = td;
            test_pass = tp;
            if (c == abort_at) abort = 1'b1;
            if (noise && c < fin && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
                enable_mask = N'($urandom);
            end
        end
        start = 1'b0; abort = 1'b0; test_done = '0;
        checks++;
        if (pass_count !== 3'(ep) || fail_count !== 3'(ef) || timeout_count !== 3'(et)) begin
            errors++;
            $display("FAIL %s counts got p%0d f%0d t%0d want p%0d f%0d t%0d", name,
                     pass_count, fail_count, timeout_count, ep, ef, et);
        end
        checks++;
        if (fail_vector !== efv) begin
            errors++;
            $display("FAIL %s fail_vector got %b want %b", name, fail_vector, efv);
        end
        checks++;
        if (all_passed !== eap || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s all_passed/busy got %b/%b want %b/0", name, all_passed, busy, eap);
        end
    endtask

    task automatic set_cfg(input int l0, l1, l2, l3, input bit p0, p1, p2, p3);
        cfg_lat[0] = l0; cfg_lat[1] = l1; cfg_lat[2] = l2; cfg_lat[3] = l3;
        cfg_pass[0] = p0; cfg_pass[1] = p1; cfg_pass[2] = p2; cfg_pass[3] = p3;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({test_start, busy, finished, all_passed, current_test, pass_count, fail_count,
             timeout_count, fail_vector} !== '0) begin
            errors++;
            $display("FAIL reset outputs got %b want 0", {test_start, busy, finished, all_passed,
                     current_test, pass_count, fail_count, timeout_count, fail_vector});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (finished !== 1'b0 || busy !== 1'b0 || test_start !== '0) begin
            errors++;
            $display("FAIL reset_idle got fin %b busy %b ts %b want 0", finished, busy, test_start);
        end
    endtask

    task automatic test_all_pass();
        set_cfg(5, 5, 5, 5, 1, 1, 1, 1);
        run_and_check("all_pass", 4'b1111, -1, 1'b0);
        checks++;
        if (all_passed !== 1'b1 || pass_count !== 3'd4) begin
            errors++;
            $display("FAIL all_pass_final got ap %b p %0d want 1 4", all_passed, pass_count);
        end
    endtask

    task automatic test_mixed();
        set_cfg(5, 4, 5, 6, 1, 1, 1, 0);
        run_and_check("mixed", 4'b1010, -1, 1'b0);
    endtask

    task automatic test_timeout();
        set_cfg(0, 3, 0, 0, 1, 1, 1, 1);
        run_and_check("timeout", 4'b0011, -1, 1'b0);
    endtask

    task automatic test_timeout_boundary();
        set_cfg(TO, TO + 1, TO - 1, TO, 1, 1, 0, 1);
        run_and_check("boundary", 4'b1111, -1, 1'b0);
    endtask

    task automatic test_foreign_done();
        set_cfg(7, 2, 6, 0, 1, 0, 1, 1);
        run_and_check("foreign_done", 4'b0101, -1, 1'b1);
    endtask

    task automatic test_abort();
        set_cfg(5, 5, 5, 5, 1, 1, 1, 1);
        run_and_check("abort", 4'b1111, 13, 1'b0);
    endtask

    task automatic test_zero_mask();
        set_cfg(5, 5, 5, 5, 1, 1, 1, 1);
        run_and_check("zero_mask", 4'b0000, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 20; r++) begin
            int ab;
            for (int ch = 0; ch < N; ch++) begin
                cfg_lat[ch] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TO + 3));
                cfg_pass[ch] = 1'($urandom);
            end
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : -1;
            run_and_check("random", N'($urandom), ab, 1'b1);
        end
    endtask

    task automatic test_reset_mid_run();
        set_cfg(0, 5, 5, 5, 1, 1, 1, 1);
        start = 1'b1; enable_mask = 4'b0001;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({test_start, busy, finished, all_passed, current_test, pass_count, fail_count,
             timeout_count, fail_vector} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run outputs got %b want 0", {test_start, busy, finished,
                     all_passed, current_test, pass_count, fail_count, timeout_count, fail_vector});
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || test_start !== '0 || finished !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run_idle got busy %b ts %b fin %b want 0", busy, test_start, finished);
        end
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_mixed();
        test_timeout();
        test_timeout_boundary();
        test_foreign_done();
        test_abort();
        test_zero_mask();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
